// File: rtl/rtc_time_core.sv
// rtc_time_core
// -------------
// Single-clock time-of-day core. An internal prescaler produces a one-second
// tick every CLK_DIV clock cycles; seconds, minutes and hours are held as
// packed BCD. Hours run either 00-23 (MODE_12H=0) or 12,01-11 with a PM flag
// (MODE_12H=1). While any SET_* input is high the clock is stopped and each
// rising edge of INCR bumps one field. A minute-resolution alarm pulses when a
// running tick lands on hh:mm:00 matching the alarm inputs.
//
// Parameters:
//   CLK_DIV   clock cycles per second tick (>= 2)
//   MODE_12H  0 = 24h hours, 1 = 12h hours with PM flag
//
// Ports:
//   CLK, RST                  clock; asynchronous active-high reset
//   SET_SEC/SET_MIN/SET_HOUR  field select levels (priority HOUR > MIN > SEC)
//   INCR                      increment request, acted on at its rising edge
//   ALARM_EN/HOUR/MIN/PM      alarm enable and BCD alarm time
//   SECOND/MINUTE/HOUR/PM     registered BCD time outputs
//   CARRY                     one-cycle pulse on day rollover
//   ALARM                     one-cycle pulse on alarm match
`timescale 1ns/1ps

module rtc_time_core #(
    parameter int CLK_DIV  = 50000000,
    parameter bit MODE_12H = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SET_SEC,
    input  logic       SET_MIN,
    input  logic       SET_HOUR,
    input  logic       INCR,
    input  logic       ALARM_EN,
    input  logic [7:0] ALARM_HOUR,
    input  logic [7:0] ALARM_MIN,
    input  logic       ALARM_PM,
    output logic [7:0] SECOND,
    output logic [7:0] MINUTE,
    output logic [7:0] HOUR,
    output logic       PM,
    output logic       CARRY,
    output logic       ALARM
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [7:0]    HOUR_RST   = MODE_12H ? 8'h12 : 8'h00;

    logic [PW-1:0] presc_q;
    logic [7:0]    second_q;
    logic [7:0]    minute_q;
    logic [7:0]    hour_q;
    logic          pm_q;
    logic          carry_q;
    logic          alarm_q;
    logic          incr_q;

    // BCD +1 for a 00..59 field.
    function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                return 8'h00;
            end
            return {v[7:4] + 4'd1, 4'd0};
        end
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD +1 for the hours field; result is {pm_next, hour_next}.
    // In 12h mode 11 -> 12 flips PM, so stepping hours walks the whole day.
    function automatic logic [8:0] hour_inc(input logic [7:0] h, input logic pm);
        logic [7:0] plain;
        plain = (h[3:0] == 4'd9) ? {h[7:4] + 4'd1, 4'd0} : {h[7:4], h[3:0] + 4'd1};
        if (MODE_12H) begin
            if (h == 8'h12) begin
                return {pm, 8'h01};
            end
            if (h == 8'h11) begin
                return {~pm, 8'h12};
            end
            return {pm, plain};
        end
        if (h == 8'h23) begin
            return {pm, 8'h00};
        end
        return {pm, plain};
    endfunction

    logic       set_mode;
    logic       incr_rise;
    logic       tick;
    logic       sec_wrap;
    logic       min_wrap;
    logic [7:0] sec_inc;
    logic [7:0] min_inc;
    logic [8:0] hr_inc;
    logic [7:0] tick_min;
    logic [7:0] tick_hour;
    logic       tick_pm;
    logic       day_wrap;
    logic       alarm_hit;

    always_comb begin
        set_mode  = SET_SEC | SET_MIN | SET_HOUR;
        incr_rise = INCR & ~incr_q;
        tick      = ~set_mode && (presc_q == PRESC_LAST);

        sec_inc   = bcd_inc59(second_q);
        min_inc   = bcd_inc59(minute_q);
        hr_inc    = hour_inc(hour_q, pm_q);
        sec_wrap  = (second_q == 8'h59);
        min_wrap  = (minute_q == 8'h59);

        // Time as it will read after a running tick.
        tick_min  = sec_wrap ? min_inc : minute_q;
        tick_hour = (sec_wrap && min_wrap) ? hr_inc[7:0] : hour_q;
        tick_pm   = (sec_wrap && min_wrap) ? hr_inc[8]   : pm_q;

        day_wrap  = sec_wrap && min_wrap &&
                    (MODE_12H ? (hour_q == 8'h11 && pm_q) : (hour_q == 8'h23));

        // Only a running tick can produce :00 seconds here, so setting the
        // time onto the alarm value cannot fire it. Stored time is always a
        // legal value, so out-of-range alarm inputs never compare equal.
        alarm_hit = ALARM_EN && sec_wrap &&
                    (tick_min == ALARM_MIN) && (tick_hour == ALARM_HOUR) &&
                    (!MODE_12H || (tick_pm == ALARM_PM));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q  <= '0;
            second_q <= 8'h00;
            minute_q <= 8'h00;
            hour_q   <= HOUR_RST;
            pm_q     <= 1'b0;
            carry_q  <= 1'b0;
            alarm_q  <= 1'b0;
            // Treat INCR as already high so a level held through reset
            // release is not seen as an edge.
            incr_q   <= 1'b1;
        end else begin
            incr_q  <= INCR;
            carry_q <= 1'b0;
            alarm_q <= 1'b0;
            if (set_mode) begin
                presc_q <= '0;
                if (incr_rise) begin
                    if (SET_HOUR) begin
                        hour_q <= hr_inc[7:0];
                        pm_q   <= hr_inc[8];
                    end else if (SET_MIN) begin
                        minute_q <= min_inc;
                    end else begin
                        second_q <= sec_inc;
                    end
                end
            end else if (tick) begin
                presc_q  <= '0;
                second_q <= sec_inc;
                minute_q <= tick_min;
                hour_q   <= tick_hour;
                pm_q     <= tick_pm;
                carry_q  <= day_wrap;
                alarm_q  <= alarm_hit;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign SECOND = second_q;
    assign MINUTE = minute_q;
    assign HOUR   = hour_q;
    assign PM     = MODE_12H ? pm_q : 1'b0;
    assign CARRY  = carry_q;
    assign ALARM  = alarm_q;

endmodule
